// File: rtl/oled_screen_arbiter_if.sv
// Pixel-bus bundle between the screen renderers, the arbiter and Oled_Display.
// Latency: none, this is wiring only.
// Backpressure: none, the display pulls pixels at its own rate.
interface oled_screen_arbiter_if;
  logic        frame_begin;
  logic [3:0]  req;
  logic [63:0] src_pixel;
  logic        lock;
  logic [3:0]  grant;
  logic [15:0] oled_data;
  logic        blanking;
  logic [7:0]  frame_count;
  logic        switch_pulse;

  // Renderer/display side: drives requests, pixels and the frame strobe.
  modport master (
    output frame_begin, req, src_pixel, lock,
    input  grant, oled_data, blanking, frame_count, switch_pulse
  );

  // Arbiter side.
  modport slave (
    input  frame_begin, req, src_pixel, lock,
    output grant, oled_data, blanking, frame_count, switch_pulse
  );
endinterface

// File: rtl/oled_screen_arbiter.sv
// Frame-aligned owner arbiter for the shared OLED pixel bus, priority to source 0.
// Latency: grant changes 4 cycles after a frame_begin rise; pixel path is combinational.
// Backpressure: none; requests are sampled only on frame edges, lock freezes switching.
module oled_screen_arbiter #(
  parameter int          N_SRC           = 4,
  parameter int          MIN_HOLD_FRAMES = 4,
  parameter int          BLANK_FRAMES    = 2,
  parameter logic [15:0] BLANK_COLOUR    = 16'h0000
) (
  input  logic                  basys_clock,
  input  logic                  reset,
  oled_screen_arbiter_if.slave  bus
);

  localparam logic [7:0] MIN_HOLD = 8'(MIN_HOLD_FRAMES);
  localparam logic [3:0] BLANK_N  = 4'(BLANK_FRAMES);

  typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_BLANK} state_t;

  // Frame-strobe synchronizer and edge detector
  logic r_fb_s1, r_fb_s2, r_fb_d;
  logic r_vld1, r_vld2;   // synchronizer holds real samples (not reset values)
  logic r_armed;          // a low level has been seen since reset
  logic r_fe;

  // FSM state
  state_t           r_state, w_state_nxt;
  logic [N_SRC-1:0] r_grant, w_grant_nxt;
  logic [7:0]       r_frame_count, w_fc_nxt;
  logic [3:0]       r_blank_cnt, w_blank_nxt;
  logic             r_pulse, w_pulse_nxt;

  logic [N_SRC-1:0] w_winner;
  logic [7:0]       w_fc_inc;
  logic [3:0]       w_blank_inc;

  // Synchronize frame_begin; only a rise seen after a real low level counts,
  // so a strobe already high when reset releases is ignored.
  always_ff @(posedge basys_clock or negedge reset) begin
    if (!reset) begin
      r_fb_s1 <= 1'b0;
      r_fb_s2 <= 1'b0;
      r_fb_d  <= 1'b0;
      r_vld1  <= 1'b0;
      r_vld2  <= 1'b0;
      r_armed <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_fb_s1 <= bus.frame_begin;
      r_fb_s2 <= r_fb_s1;
      r_fb_d  <= r_fb_s2;
      r_vld1  <= 1'b1;
      r_vld2  <= r_vld1;
      r_armed <= r_armed | (r_vld2 & ~r_fb_s2);
      r_fe    <= r_armed & r_fb_s2 & ~r_fb_d;
    end
  end

  // Fixed-priority winner: lowest requesting index
  always_comb begin
    w_winner = '0;
    if      (bus.req[0]) w_winner = 4'b0001;
    else if (bus.req[1]) w_winner = 4'b0010;
    else if (bus.req[2]) w_winner = 4'b0100;
    else if (bus.req[3]) w_winner = 4'b1000;
  end

  assign w_fc_inc    = (r_frame_count == 8'hFF) ? 8'hFF : r_frame_count + 8'd1;
  assign w_blank_inc = r_blank_cnt + 4'd1;

  // Next-state logic: all decisions taken on the frame edge only
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_fc_nxt    = r_frame_count;
    w_blank_nxt = r_blank_cnt;
    w_pulse_nxt = 1'b0;
    if (r_fe) begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.lock && (|bus.req)) begin
            w_state_nxt = ST_SHOW;
            w_grant_nxt = w_winner;
            w_fc_nxt    = 8'd0;
            w_pulse_nxt = 1'b1;
          end
        end
        ST_SHOW: begin
          w_fc_nxt = w_fc_inc;
          if (!bus.lock) begin
            // One-hot compare: a smaller value is a higher-priority source.
            if (((bus.req & r_grant) == '0) ||
                ((w_winner < r_grant) && (w_fc_inc >= MIN_HOLD))) begin
              w_state_nxt = ST_BLANK;
              w_grant_nxt = '0;
              w_fc_nxt    = 8'd0;
              w_blank_nxt = 4'd0;
            end
          end
        end
        ST_BLANK: begin
          if (!bus.lock) begin
            if (w_blank_inc == BLANK_N) begin
              w_blank_nxt = 4'd0;
              if (|bus.req) begin
                w_state_nxt = ST_SHOW;
                w_grant_nxt = w_winner;
                w_fc_nxt    = 8'd0;
                w_pulse_nxt = 1'b1;
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end else begin
              w_blank_nxt = w_blank_inc;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_fc_nxt    = 8'd0;
          w_blank_nxt = 4'd0;
        end
      endcase
    end
  end

  // FSM state registers
  always_ff @(posedge basys_clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_frame_count <= 8'd0;
      r_blank_cnt   <= 4'd0;
      r_pulse       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_frame_count <= w_fc_nxt;
      r_blank_cnt   <= w_blank_nxt;
      r_pulse       <= w_pulse_nxt;
    end
  end

  // Pixel mux keyed on the registered grant; blank colour when nobody owns the bus
  always_comb begin
    case (r_grant)
      4'b0001: bus.oled_data = bus.src_pixel[15:0];
      4'b0010: bus.oled_data = bus.src_pixel[31:16];
      4'b0100: bus.oled_data = bus.src_pixel[47:32];
      4'b1000: bus.oled_data = bus.src_pixel[63:48];
      default: bus.oled_data = BLANK_COLOUR;
    endcase
  end

  assign bus.grant        = r_grant;
  assign bus.blanking     = (r_state != ST_SHOW);
  assign bus.frame_count  = r_frame_count;
  assign bus.switch_pulse = r_pulse;

endmodule

// File: tb/tb_oled_screen_arbiter.sv
// Directed bench for oled_screen_arbiter: frame-by-frame vector table plus
// hand sequences for latency, reset with a high strobe, req glitches and saturation.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_oled_screen_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  bit   multi_hot;

  oled_screen_arbiter_if u_bus ();

  oled_screen_arbiter #(
    .N_SRC(4), .MIN_HOLD_FRAMES(4), .BLANK_FRAMES(2), .BLANK_COLOUR(16'h0000)
  ) u_dut (
    .basys_clock(clk),
    .reset      (rst_n),
    .bus        (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic        lock;
    logic [3:0]  grant;
    logic        blanking;
    logic [7:0]  fc;
    logic [7:0]  pulses;
    logic [15:0] oled;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One display frame: strobe high 16 cycles then low 8; counts switch pulses.
  task automatic frame(output int pulses);
    pulses = 0;
    u_bus.frame_begin = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c == 16) u_bus.frame_begin = 1'b0;
      @(negedge clk);
      if (u_bus.switch_pulse) pulses++;
      if ($countones(u_bus.grant) > 1) multi_hot = 1'b1;
    end
  endtask

  task automatic add(input logic [3:0] r, input logic l, input logic [3:0] g,
                     input logic b, input logic [7:0] f, input logic [7:0] p,
                     input logic [15:0] o);
    vec_t v;
    v = '{req: r, lock: l, grant: g, blanking: b, fc: f, pulses: p, oled: o};
    tbl.push_back(v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " grant"},        32'(u_bus.grant),        32'h0);
    check({tag, " blanking"},     32'(u_bus.blanking),     32'h1);
    check({tag, " oled_data"},    32'(u_bus.oled_data),    32'h0);
    check({tag, " frame_count"},  32'(u_bus.frame_count),  32'h0);
    check({tag, " switch_pulse"}, 32'(u_bus.switch_pulse), 32'h0);
  endtask

  initial begin
    int p;
    checks    = 0;
    failures  = 0;
    multi_hot = 1'b0;

    // Owner 2 holding, higher-priority 0 arrives: blank after hold time
    add(4'b0101, 0, 4'b0100, 0, 8'd1, 0, 16'hC002);
    add(4'b0101, 0, 4'b0100, 0, 8'd2, 0, 16'hC002);
    add(4'b0101, 0, 4'b0100, 0, 8'd3, 0, 16'hC002);
    add(4'b0101, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b0101, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b0101, 0, 4'b0001, 0, 8'd0, 1, 16'hA000);
    // Owner 0 drops, source 1 takes over via blank frames
    add(4'b0010, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b0010, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b0010, 0, 4'b0010, 0, 8'd0, 1, 16'hB001);
    // Owner 1 drops with nothing pending: blank twice then idle
    add(4'b0000, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b0000, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b0000, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    // Owner 3 under lock for 10 frames with source 0 pending
    add(4'b1000, 0, 4'b1000, 0, 8'd0, 1, 16'hD003);
    for (int k = 1; k <= 10; k++) add(4'b1001, 1, 4'b1000, 0, 8'(k), 0, 16'hD003);
    add(4'b1001, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b1001, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b1001, 0, 4'b0001, 0, 8'd0, 1, 16'hA000);
    // Lock freezes the blank counter
    add(4'b1000, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b1000, 1, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b1000, 1, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b1000, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b1000, 0, 4'b1000, 0, 8'd0, 1, 16'hD003);
    // Owner drops while higher priority requests (before hold); owner re-requests in blank
    add(4'b0001, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b1001, 0, 4'b0000, 1, 8'd0, 0, 16'h0000);
    add(4'b1001, 0, 4'b0001, 0, 8'd0, 1, 16'hA000);

    u_bus.frame_begin = 1'b0;
    u_bus.req         = 4'b0000;
    u_bus.lock        = 1'b0;
    u_bus.src_pixel   = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
    rst_n             = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Latency: grant appears exactly 4 cycles after the strobe rise
    u_bus.req = 4'b0100;
    u_bus.frame_begin = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c < 4) check($sformatf("lat c%0d grant", c), 32'(u_bus.grant), 32'h0);
      if (c == 4) begin
        check("lat grant", 32'(u_bus.grant), 32'h4);
        check("lat pulse", 32'(u_bus.switch_pulse), 32'h1);
        check("lat oled", 32'(u_bus.oled_data), 32'hC002);
        check("lat blanking", 32'(u_bus.blanking), 32'h0);
      end
      if (c == 5) check("lat pulse width", 32'(u_bus.switch_pulse), 32'h0);
    end
    repeat (11) @(negedge clk);
    u_bus.frame_begin = 1'b0;
    repeat (8) @(negedge clk);

    // Frame-by-frame table
    for (int i = 0; i < tbl.size(); i++) begin
      u_bus.req  = tbl[i].req;
      u_bus.lock = tbl[i].lock;
      frame(p);
      check($sformatf("row%0d grant", i),    32'(u_bus.grant),       32'(tbl[i].grant));
      check($sformatf("row%0d blanking", i), 32'(u_bus.blanking),    32'(tbl[i].blanking));
      check($sformatf("row%0d fc", i),       32'(u_bus.frame_count), 32'(tbl[i].fc));
      check($sformatf("row%0d pulses", i),   32'(p),                 32'(tbl[i].pulses));
      check($sformatf("row%0d oled", i),     32'(u_bus.oled_data),   32'(tbl[i].oled));
    end
    u_bus.lock = 1'b0;

    // Reset mid-frame while showing source 0, strobe still high at release
    u_bus.frame_begin = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst show");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    check("rst show no fe grant", 32'(u_bus.grant), 32'h0);
    u_bus.frame_begin = 1'b0;
    repeat (8) @(negedge clk);
    frame(p);
    check("rst show regrant", 32'(u_bus.grant), 32'h1);
    check("rst show regrant pulses", 32'(p), 32'h1);

    // Reset during a BLANK frame
    u_bus.req = 4'b0000;
    frame(p);
    check("to blank blanking", 32'(u_bus.blanking), 32'h1);
    u_bus.req = 4'b0001;
    u_bus.frame_begin = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst blank");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst blank no fe grant", 32'(u_bus.grant), 32'h0);
    u_bus.frame_begin = 1'b0;
    repeat (8) @(negedge clk);
    frame(p);
    check("rst blank idle->show grant", 32'(u_bus.grant), 32'h1);
    check("rst blank idle->show fc", 32'(u_bus.frame_count), 32'h0);

    // req glitches between frame edges are ignored
    p = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 0)  u_bus.req = 4'b0000;
      if (c == 20) u_bus.req = 4'b1010;
      if (c == 40) u_bus.req = 4'b0001;
      @(negedge clk);
      if (u_bus.switch_pulse) p++;
    end
    check("glitch grant", 32'(u_bus.grant), 32'h1);
    check("glitch fc", 32'(u_bus.frame_count), 32'h0);
    check("glitch pulses", 32'(p), 32'h0);
    frame(p);
    check("after glitch fc", 32'(u_bus.frame_count), 32'h1);

    // frame_count saturates at 255 while the sole requester keeps the screen
    for (int f = 0; f < 260; f++) frame(p);
    check("sat fc", 32'(u_bus.frame_count), 32'hFF);
    check("sat grant", 32'(u_bus.grant), 32'h1);

    check("grant never multi-hot", 32'(multi_hot), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oled_screen_arbiter.md
# oled_screen_arbiter

Shares the single 96x64 OLED pixel bus between up to four screen sources (menu, maze, wire-cut stage, result screen) by driving `oled_data` from one granted source at a time. Ownership changes only at frame boundaries signalled by `Oled_Display`'s `frame_begin`, with blank frames inserted between owners so a frame never mixes two screens. Sits between the per-screen renderers and `Oled_Display`, clocked from `basys_clock`.

## Interface
- `N_SRC`, 4: number of requesters. Fixed at 4; index 0 has the highest priority.
- `MIN_HOLD_FRAMES`, 4: minimum frames an owner keeps the grant before it can be pre-empted. Legal range 1..255.
- `BLANK_FRAMES`, 2: blank frames inserted on every owner change. Legal range 1..15.
- `BLANK_COLOUR`, 16'h0000: RGB565 value driven while no source is granted.

- `basys_clock`  in  1  100 MHz system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frame_begin`  in  1  `Oled_Display` frame strobe from the 6.25 MHz domain, high about 16 `basys_clock` cycles.
- `req`  in  4  per-source request level; bit i means source i wants the screen.
- `src_pixel`  in  64  source i pixel at bits [16i+15:16i], combinational from `pixel_index`.
- `lock`  in  1  when 1, the FSM stays in its current state (no switches).
- `grant`  out  4  one-hot owner, or all zeros in IDLE/BLANK.
- `oled_data`  out  16  pixel data to `Oled_Display`.
- `blanking`  out  1  high in IDLE and BLANK.
- `frame_count`  out  8  frames since the current grant started; saturates at 255.
- `switch_pulse`  out  1  one-cycle pulse when a new grant takes effect.

## Operation
- Frame edge: `frame_begin` passes through a 2-flop synchronizer and a rising-edge detector to form `fe`, a one-cycle pulse. All state decisions happen only on `fe`. `req` changes between edges are ignored.
- Winner: the lowest index i with `req[i]`=1.
- IDLE: `grant`=0, `blanking`=1.
  - On `fe` with any request: go to SHOW with `grant` = winner, `frame_count`=0, and pulse `switch_pulse`. No blank frames are inserted from IDLE.
- SHOW: `oled_data` = `src_pixel` of the owner. On `fe`, `frame_count` increments with saturation. Then, unless `lock`=1:
  - Owner's `req`=0: go to BLANK, ignoring the hold time.
  - Winner has a higher priority than the owner and the updated `frame_count` ≥ `MIN_HOLD_FRAMES`: go to BLANK.
  - Otherwise stay in SHOW.
- BLANK: `grant`=0, `oled_data`=`BLANK_COLOUR`, `blanking`=1. A blank counter increments on each `fe`. When it reaches `BLANK_FRAMES`, the winner is re-evaluated at that edge:
  - Any request: go to SHOW, `frame_count`=0, pulse `switch_pulse`.
  - No request: go to IDLE.
- `lock`=1 freezes the state and the blank counter. `frame_count` keeps counting in SHOW.
- `oled_data` is a combinational mux of the registered `grant`, so a source's pixel path adds no latency.
- `frame_count` is 0 outside SHOW.

## Timing
- Reset (asynchronous, `reset`=0), all outputs:
  - state IDLE
  - `grant`=4'b0000
  - `oled_data`=`BLANK_COLOUR`
  - `blanking`=1
  - `frame_count`=0
  - `switch_pulse`=0
  - synchronizer and counters cleared.
- Reset asserted mid-frame or mid-BLANK returns to IDLE immediately. After release, the first `fe` needs a fresh rising edge of `frame_begin`: a `frame_begin` that is already high at release does not create an `fe`.
- Latency: `frame_begin` rise, then `fe` 3 cycles later, then `grant`, `blanking` and `switch_pulse` update on the next edge. Total is 4 `basys_clock` cycles, well before pixel 0 is sampled.
- `switch_pulse` is high for exactly 1 cycle, in the cycle the new `grant` first appears.
- Simultaneous events:
  - Owner drops `req` on the same `fe` as a higher-priority request: go to BLANK.
  - `req` for the owner rises again during BLANK: still decided by re-evaluation at the end of BLANK.
- `grant` is never multi-hot. Every transition between two distinct non-zero `grant` values passes through exactly `BLANK_FRAMES` frames with `grant`=0.

## Test plan
- Reset, then `req`=4'b0100 and one `frame_begin` → `grant`=4'b0100 exactly 4 cycles after the rise, one-cycle `switch_pulse`, `oled_data` follows `src_pixel[47:32]`.
- Owner 2 holding, `req`=4'b0101 raised at frame 1 → BLANK entered on the 4th `fe` after the grant (`frame_count`=4). Then 2 frames with `grant`=0 and `oled_data`=16'h0000, then `grant`=4'b0001.
- Owner 1, `req` drops to 0 at frame 1 → BLANK on the next `fe`. After 2 blank frames with no requests: IDLE, `blanking`=1, `grant`=0.
- `lock`=1 with owner 3 and `req`=4'b1001 for 10 frames → `grant` stays 4'b1000 and `frame_count`=10. Releasing `lock` → BLANK on the next `fe`.
- `reset` pulsed low during a BLANK frame → all outputs return to reset values within the same cycle. A `frame_begin` already high at release causes no grant until its next rising edge.
- `req` toggled between `fe` pulses with 20-cycle glitches → `grant`, `frame_count` and `switch_pulse` unchanged.
